// File: rtl/lsab_cw_drain_pkg.sv
// Shared definitions for the LSAB drain: FIFO geometry, return latency,
// arbiter state encoding and the skid-buffer word layout.
package lsab_cw_drain_pkg;

  localparam int LSAB_NFIFO  = 4;
  localparam int LSAB_FIDW   = 2;
  localparam int LSAB_RD_LAT = 2;
  localparam int SKID_DEPTH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_STALL = 2'd2
  } drain_state_t;

  typedef struct packed {
    logic [LSAB_FIDW-1:0] fifo;
    logic [31:0]          data;
  } skid_word_t;

  // Returns {found, index} of the first requester at or after ptr, wrapping.
  function automatic logic [LSAB_FIDW:0] rr_pick(input logic [LSAB_FIDW-1:0] ptr,
                                                  input logic [LSAB_NFIFO-1:0] req);
    logic [LSAB_FIDW:0]   res;
    logic [LSAB_FIDW-1:0] idx;
    res = '0;
    for (int i = LSAB_NFIFO - 1; i >= 0; i--) begin
      idx = ptr + LSAB_FIDW'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/lsab_cw_drain_skid.sv
// Four-entry skid FIFO holding returned LSAB words in issue order.
// The head is read straight from registered storage and drives DOUT.
module lsab_cw_drain_skid
  import lsab_cw_drain_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       push,
  input  skid_word_t push_word,
  input  logic       pop,
  output logic [2:0] occ,
  output skid_word_t head
);

  skid_word_t mem [SKID_DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      occ <= occ + 3'(push) - 3'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/lsab_cw_drain.sv
// Drains the four lsab_cw FIFOs into one tagged stream. Occupancy is tracked
// by snooping the write port; bursts are granted round-robin under a credit limit.
module lsab_cw_drain
  import lsab_cw_drain_pkg::*;
#(
  parameter int LSAB_AW   = 5,
  parameter int BURST_LEN = 4,
  parameter int RD_LAT    = LSAB_RD_LAT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SNOOP_WRITE,
  input  logic [1:0]  SNOOP_WFIFO,
  output logic        LSAB_READ,
  output logic [1:0]  LSAB_READ_FIFO,
  input  logic [31:0] LSAB_OUT_0,
  input  logic [31:0] LSAB_OUT_1,
  input  logic [31:0] LSAB_OUT_2,
  input  logic [31:0] LSAB_OUT_3,
  input  logic [3:0]  ENABLE,
  output logic [31:0] DOUT,
  output logic [1:0]  DOUT_FIFO,
  output logic        DOUT_VALID,
  input  logic        DOUT_READY,
  output logic        OVERFLOW
);

  localparam int              CW       = LSAB_AW + 1;
  localparam logic [CW-1:0]   CNT_FULL = CW'(1 << LSAB_AW);
  localparam logic [3:0]      BLAST    = 4'(BURST_LEN - 1);

  logic [CW-1:0]   cnt [LSAB_NFIFO];
  logic [3:0]      wr_hit, rd_hit, req;
  logic [2:0]      pick;
  drain_state_t    state;
  logic [1:0]      grant, rr_ptr;
  logic [3:0]      bcnt;
  logic [RD_LAT-1:0] pipe_v;
  logic [1:0]      pipe_f [RD_LAT];
  logic [2:0]      inflight, skid_occ;
  logic            credit_ok, issue, pop;
  logic [CW-1:0]   grant_cnt_after;
  skid_word_t      ret_word, head;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + 3'(pipe_v[i]);
  end

  // Words already in the skid plus those still returning must fit in the skid.
  assign credit_ok = ({1'b0, skid_occ} + {1'b0, inflight}) < 4'd4;
  assign issue     = (state == ST_BURST) && credit_ok;

  always_comb begin
    for (int f = 0; f < LSAB_NFIFO; f++) begin
      wr_hit[f] = SNOOP_WRITE && (SNOOP_WFIFO == 2'(f));
      rd_hit[f] = issue && (grant == 2'(f));
      req[f]    = ENABLE[f] && (cnt[f] != '0);
    end
  end

  assign pick            = rr_pick(rr_ptr, req);
  assign grant_cnt_after = cnt[grant] - CW'(1) + CW'(wr_hit[grant]);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int f = 0; f < LSAB_NFIFO; f++) cnt[f] <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      for (int f = 0; f < LSAB_NFIFO; f++) begin
        if (wr_hit[f] && !rd_hit[f] && cnt[f] != CNT_FULL) cnt[f] <= cnt[f] + CW'(1);
        else if (rd_hit[f] && !wr_hit[f])                  cnt[f] <= cnt[f] - CW'(1);
      end
      if (SNOOP_WRITE && cnt[SNOOP_WFIFO] == CNT_FULL) OVERFLOW <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= ST_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      bcnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick[2]) begin
            grant <= pick[1:0];
            bcnt  <= '0;
            state <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (!credit_ok) begin
            state <= ST_STALL;
          end else begin
            bcnt <= bcnt + 4'd1;
            if (bcnt == BLAST || grant_cnt_after == '0 || !ENABLE[grant]) begin
              rr_ptr <= grant + 2'd1;
              state  <= ST_IDLE;
            end
          end
        end
        ST_STALL: begin
          if (!ENABLE[grant]) begin
            rr_ptr <= grant + 2'd1;
            state  <= ST_IDLE;
          end else if (credit_ok) begin
            state <= ST_BURST;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pipe_v <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_f[i] <= '0;
    end else begin
      pipe_v    <= {pipe_v[RD_LAT-2:0], issue};
      pipe_f[0] <= grant;
      for (int i = 1; i < RD_LAT; i++) pipe_f[i] <= pipe_f[i-1];
    end
  end

  always_comb begin
    ret_word.fifo = pipe_f[RD_LAT-1];
    case (pipe_f[RD_LAT-1])
      2'd0:    ret_word.data = LSAB_OUT_0;
      2'd1:    ret_word.data = LSAB_OUT_1;
      2'd2:    ret_word.data = LSAB_OUT_2;
      default: ret_word.data = LSAB_OUT_3;
    endcase
  end

  assign pop = DOUT_VALID && DOUT_READY;

  lsab_cw_drain_skid u_skid (
    .CLK       (CLK),
    .RST       (RST),
    .push      (pipe_v[RD_LAT-1]),
    .push_word (ret_word),
    .pop       (pop),
    .occ       (skid_occ),
    .head      (head)
  );

  assign LSAB_READ      = issue;
  assign LSAB_READ_FIFO = grant;
  assign DOUT           = head.data;
  assign DOUT_FIFO      = head.fifo;
  assign DOUT_VALID     = skid_occ != 3'd0;

endmodule
